// File: rtl/simple_spi_pkg.sv
// Shared types and constants for the simple SPI master (mode 0, MSB first).
package simple_spi_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SCK_LOW  = 2'd1,
      SCK_HIGH = 2'd2
   } spi_state_e;

   localparam int unsigned DEFAULT_CLK_DIV = 2;

   localparam logic T_DRIVE = 1'b0;
   localparam logic T_HIZ   = 1'b1;

   // Divider counter width; at least one bit even when CLK_DIV is 1.
   function automatic int unsigned div_width(input int unsigned div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/simple_spi_shifter.sv
// 8-bit transmit/receive shift pair with a down-counting bit index.
module simple_spi_shifter (
   input  logic       clock,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] load_data,
   input  logic       sample_strobe,
   input  logic       sample_bit,
   input  logic       shift_strobe,
   output logic       tx_msb,
   output logic [7:0] rx_data,
   output logic       last_bit
);

   logic [7:0] tx_reg;
   logic [7:0] rx_reg;
   logic [2:0] bit_cnt;

   always_ff @(posedge clock) begin
      if (rst) begin
         tx_reg  <= '0;
         rx_reg  <= '0;
         bit_cnt <= '0;
      end else if (load) begin
         tx_reg  <= load_data;
         bit_cnt <= 3'd7;
      end else begin
         if (sample_strobe) begin
            rx_reg <= {rx_reg[6:0], sample_bit};
         end
         if (shift_strobe) begin
            tx_reg  <= {tx_reg[6:0], 1'b0};
            bit_cnt <= bit_cnt - 3'd1;
         end
      end
   end

   assign tx_msb   = tx_reg[7];
   assign rx_data  = rx_reg;
   assign last_bit = (bit_cnt == 3'd0);

endmodule

// File: rtl/simple_spi_master.sv
// Byte-oriented SPI master, mode 0, MSB first, with Xilinx-style tristate pads.
module simple_spi_master
   import simple_spi_pkg::*;
#(
   parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
   input  logic       clock,
   input  logic       rst,
   input  logic       spi_csn,
   input  logic       rd_en_i,
   input  logic       wr_en_i,
   input  logic [7:0] wr_data_i,
   output logic [7:0] rd_data_o,
   output logic       busy_o,
   input  logic       spi_csn_i,
   output logic       spi_csn_o,
   output logic       spi_csn_t,
   input  logic       spi_sck_i,
   output logic       spi_sck_o,
   output logic       spi_sck_t,
   input  logic       spi_mosi_i,
   output logic       spi_mosi_o,
   output logic       spi_mosi_t,
   input  logic       spi_miso_i,
   output logic       spi_miso_o,
   output logic       spi_miso_t
);

   localparam int unsigned DIV_W = div_width(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   spi_state_e       state, state_nxt;
   logic [DIV_W-1:0] div_cnt;
   logic             div_done;
   logic             sck_q, sck_nxt;
   logic             csn_q;
   logic [7:0]       rd_data_q;

   logic             load, sample_strobe, shift_strobe, rd_load;
   logic [7:0]       load_data;
   logic             tx_msb, last_bit;
   logic [7:0]       rx_data;

   assign div_done = (div_cnt == DIV_LAST);

   always_ff @(posedge clock) begin
      if (rst) begin
         state     <= IDLE;
         sck_q     <= 1'b0;
         csn_q     <= 1'b1;
         rd_data_q <= '0;
      end else begin
         state <= state_nxt;
         sck_q <= sck_nxt;
         csn_q <= spi_csn;
         if (rd_load) begin
            rd_data_q <= rx_data;
         end
      end
   end

   // Divider restarts on every state change so each SCK phase lasts CLK_DIV cycles.
   always_ff @(posedge clock) begin
      if (rst || state == IDLE || state_nxt != state) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   always_comb begin
      state_nxt     = state;
      sck_nxt       = sck_q;
      load          = 1'b0;
      sample_strobe = 1'b0;
      shift_strobe  = 1'b0;
      rd_load       = 1'b0;
      load_data     = wr_en_i ? wr_data_i : 8'h00;
      case (state)
         IDLE: begin
            if (wr_en_i || rd_en_i) begin
               load      = 1'b1;
               sck_nxt   = 1'b0;
               state_nxt = SCK_LOW;
            end
         end
         SCK_LOW: begin
            if (div_done) begin
               sck_nxt       = 1'b1;
               sample_strobe = 1'b1;
               state_nxt     = SCK_HIGH;
            end
         end
         SCK_HIGH: begin
            if (div_done) begin
               sck_nxt = 1'b0;
               if (last_bit) begin
                  rd_load   = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  shift_strobe = 1'b1;
                  state_nxt    = SCK_LOW;
               end
            end
         end
         default: begin
            sck_nxt   = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   simple_spi_shifter u_shifter (
      .clock         (clock),
      .rst           (rst),
      .load          (load),
      .load_data     (load_data),
      .sample_strobe (sample_strobe),
      .sample_bit    (spi_miso_i),
      .shift_strobe  (shift_strobe),
      .tx_msb        (tx_msb),
      .rx_data       (rx_data),
      .last_bit      (last_bit)
   );

   assign busy_o    = (state != IDLE);
   assign rd_data_o = rd_data_q;

   assign spi_csn_o  = csn_q;
   assign spi_csn_t  = T_DRIVE;
   assign spi_sck_o  = sck_q;
   assign spi_sck_t  = T_DRIVE;
   assign spi_mosi_o = tx_msb;
   assign spi_mosi_t = T_DRIVE;
   assign spi_miso_o = 1'b0;
   assign spi_miso_t = T_HIZ;

   logic unused_pads;
   assign unused_pads = ^{spi_csn_i, spi_sck_i, spi_mosi_i};

endmodule

// File: tb/tb_simple_spi_master.sv
// Directed self-checking bench for simple_spi_master with a mode-0 slave model.
module tb_simple_spi_master;

   logic       clock = 1'b0;
   logic       rst = 1'b1;
   logic       spi_csn = 1'b1;
   logic       rd_en_i = 1'b0;
   logic       wr_en_i = 1'b0;
   logic [7:0] wr_data_i = 8'h00;
   logic [7:0] rd_data_o;
   logic       busy_o;
   logic       spi_csn_o, spi_csn_t;
   logic       spi_sck_o, spi_sck_t;
   logic       spi_mosi_o, spi_mosi_t;
   logic       spi_miso_i = 1'b0;
   logic       spi_miso_o, spi_miso_t;

   int unsigned total = 0;
   int unsigned bad = 0;

   // slave / monitor state
   logic [7:0]  slave_byte = 8'h00;
   logic [7:0]  mosi_cap = 8'h00;
   logic        sck_prev = 1'b0;
   int unsigned rise_idx = 0;
   int unsigned rise_total = 0;
   int unsigned busy_total = 0;
   int unsigned csn_hi_busy = 0;

   simple_spi_master #(.CLK_DIV(2)) dut (
      .clock      (clock),
      .rst        (rst),
      .spi_csn    (spi_csn),
      .rd_en_i    (rd_en_i),
      .wr_en_i    (wr_en_i),
      .wr_data_i  (wr_data_i),
      .rd_data_o  (rd_data_o),
      .busy_o     (busy_o),
      .spi_csn_i  (1'b1),
      .spi_csn_o  (spi_csn_o),
      .spi_csn_t  (spi_csn_t),
      .spi_sck_i  (1'b0),
      .spi_sck_o  (spi_sck_o),
      .spi_sck_t  (spi_sck_t),
      .spi_mosi_i (1'b0),
      .spi_mosi_o (spi_mosi_o),
      .spi_mosi_t (spi_mosi_t),
      .spi_miso_i (spi_miso_i),
      .spi_miso_o (spi_miso_o),
      .spi_miso_t (spi_miso_t)
   );

   always #5 clock = ~clock;

   // Slave presents bit (7 - rises so far); MOSI captured right after each SCK rise.
   always @(negedge clock) begin
      logic rise;
      rise = (spi_sck_o === 1'b1) && (sck_prev == 1'b0);
      if (rise) begin
         rise_total = rise_total + 1;
         mosi_cap   = {mosi_cap[6:0], spi_mosi_o};
      end
      if (busy_o !== 1'b1) begin
         rise_idx = 0;
      end else begin
         busy_total = busy_total + 1;
         if (spi_csn_o !== 1'b0) csn_hi_busy = csn_hi_busy + 1;
         if (rise) rise_idx = rise_idx + 1;
      end
      spi_miso_i = (rise_idx < 8) ? slave_byte[3'(7 - rise_idx)] : 1'b0;
      sck_prev   = (spi_sck_o === 1'b1);
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total = total + 1;
      if (got !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_idle(input string tag);
      bit done;
      done = 0;
      for (int i = 0; i < 200; i++) begin
         if (busy_o == 1'b0) begin
            done = 1;
            break;
         end
         tick();
      end
      if (!done) check_val({tag, "_timeout"}, 32'd1, 32'd0);
   endtask

   // Starts a transfer from an idle cycle and returns in the first idle cycle after it.
   task automatic do_xfer(input string tag, input logic wr, input logic rd,
                          input logic [7:0] data, input logic [7:0] slave,
                          output int unsigned rises, output int unsigned busy_cyc);
      int unsigned r0, b0;
      logic [7:0] sent;
      sent       = wr ? data : 8'h00;
      slave_byte = slave;
      wr_en_i    = wr;
      rd_en_i    = rd;
      wr_data_i  = data;
      r0 = rise_total;
      b0 = busy_total;
      tick();
      wr_en_i = 1'b0;
      rd_en_i = 1'b0;
      check_val({tag, "_start_busy"}, 32'(busy_o), 32'd1);
      check_val({tag, "_start_sck"}, 32'(spi_sck_o), 32'd0);
      check_val({tag, "_start_mosi"}, 32'(spi_mosi_o), 32'(sent[7]));
      wait_idle(tag);
      rises    = rise_total - r0;
      busy_cyc = busy_total - b0;
   endtask

   initial begin
      int unsigned rises, bcyc, r0, stray;
      logic [7:0] stream [9];
      stream = '{8'h0B, 8'h12, 8'h34, 8'h56, 8'h70, 8'hBA, 8'hDC, 8'h0F, 8'hFE};

      // reset values and pads
      repeat (3) tick();
      check_val("rst_sck", 32'(spi_sck_o), 32'd0);
      check_val("rst_mosi", 32'(spi_mosi_o), 32'd0);
      check_val("rst_busy", 32'(busy_o), 32'd0);
      check_val("rst_rd_data", 32'(rd_data_o), 32'h00);
      check_val("rst_csn_o", 32'(spi_csn_o), 32'd1);
      check_val("pad_t", {28'd0, spi_csn_t, spi_sck_t, spi_mosi_t, spi_miso_t}, 32'b0001);
      check_val("miso_o", 32'(spi_miso_o), 32'd0);
      rst = 1'b0;
      tick();

      // single byte
      spi_csn = 1'b0;
      tick();
      do_xfer("single", 1'b1, 1'b0, 8'h0B, 8'hA5, rises, bcyc);
      check_val("single_mosi", 32'(mosi_cap), 32'h0B);
      check_val("single_rd", 32'(rd_data_o), 32'hA5);
      check_val("single_busy_cycles", bcyc, 32'd32);
      check_val("single_sck_pulses", rises, 32'd8);

      // back-to-back stream, slave returns F0, F1, ...
      for (int i = 0; i < 9; i++) begin
         do_xfer($sformatf("stream%0d", i), 1'b1, 1'b0, stream[i], 8'(8'hF0 + i), rises, bcyc);
         check_val($sformatf("stream%0d_mosi", i), 32'(mosi_cap), 32'(stream[i]));
         check_val($sformatf("stream%0d_rd", i), 32'(rd_data_o), 32'(8'hF0 + i));
         check_val($sformatf("stream%0d_csn_o", i), 32'(spi_csn_o), 32'd0);
      end
      check_val("stream_csn_hi_busy", csn_hi_busy, 32'd0);

      // read-only and enable priority
      do_xfer("read", 1'b0, 1'b1, 8'hFF, 8'h69, rises, bcyc);
      check_val("read_mosi", 32'(mosi_cap), 32'h00);
      check_val("read_rd", 32'(rd_data_o), 32'h69);
      do_xfer("prio", 1'b1, 1'b1, 8'h3C, 8'h81, rises, bcyc);
      check_val("prio_mosi", 32'(mosi_cap), 32'h3C);
      check_val("prio_rd", 32'(rd_data_o), 32'h81);

      // enable while busy is ignored
      slave_byte = 8'h5A;
      wr_en_i    = 1'b1;
      wr_data_i  = 8'hA0;
      r0 = rise_total;
      tick();
      wr_en_i = 1'b0;
      repeat (10) tick();
      wr_en_i   = 1'b1;
      wr_data_i = 8'h55;
      tick();
      wr_en_i = 1'b0;
      wait_idle("busyprot");
      check_val("busyprot_mosi", 32'(mosi_cap), 32'hA0);
      check_val("busyprot_rd", 32'(rd_data_o), 32'h5A);
      check_val("busyprot_pulses", rise_total - r0, 32'd8);
      stray = 0;
      for (int i = 0; i < 40; i++) begin
         if (busy_o !== 1'b0) stray = stray + 1;
         tick();
      end
      check_val("busyprot_no_second", stray, 32'd0);

      // reset mid-transfer
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_val("rst2_rd_data", 32'(rd_data_o), 32'h00);
      slave_byte = 8'h77;
      wr_en_i    = 1'b1;
      wr_data_i  = 8'hC3;
      r0 = rise_total;
      tick();
      wr_en_i = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (rise_total - r0 >= 4) break;
         tick();
      end
      check_val("abort_reached_bit4", rise_total - r0, 32'd4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_val("abort_sck", 32'(spi_sck_o), 32'd0);
      check_val("abort_busy", 32'(busy_o), 32'd0);
      check_val("abort_rd", 32'(rd_data_o), 32'h00);
      repeat (5) tick();
      check_val("abort_rd_hold", 32'(rd_data_o), 32'h00);
      check_val("abort_busy_hold", 32'(busy_o), 32'd0);
      do_xfer("fresh", 1'b1, 1'b0, 8'h96, 8'h3E, rises, bcyc);
      check_val("fresh_mosi", 32'(mosi_cap), 32'h96);
      check_val("fresh_rd", 32'(rd_data_o), 32'h3E);
      check_val("fresh_pulses", rises, 32'd8);
      check_val("fresh_mosi_hold", 32'(spi_mosi_o), 32'd0);

      // chip select lags one cycle
      spi_csn = 1'b1;
      #1;
      check_val("csn_lag_before", 32'(spi_csn_o), 32'd0);
      tick();
      check_val("csn_lag_after", 32'(spi_csn_o), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got=running expected=finished");
      $fatal(1);
   end

endmodule
